// File: rtl/exmem_pkg.sv
// Shared types and constants for the external-memory Wishbone slave:
// FSM encoding, CSR byte offsets and the access-counter width.
package exmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_PF
    } state_t;

    localparam int CNT_W = 32;

    localparam logic [19:0] CSR_CTRL   = 20'h0_0000;
    localparam logic [19:0] CSR_RD_CNT = 20'h0_0004;
    localparam logic [19:0] CSR_WR_CNT = 20'h0_0008;
    localparam logic [19:0] CSR_PF_HIT = 20'h0_000C;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/exmem_bram.sv
// Single-port BRAM: one-cycle synchronous read, per-byte write enables.
// Read-during-write returns the old word.
module exmem_bram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_exmem_ctrl.sv
// Wishbone slave for the user-area external memory: decoded memory and
// CSR windows, run-time wait states, one-entry read prefetch, counters.
module wb_exmem_ctrl
    import exmem_pkg::*;
#(
    parameter int          MEM_AW     = 12,
    parameter logic [11:0] MEM_BASE   = 12'h380,
    parameter logic [11:0] CSR_BASE   = 12'h381,
    parameter int          RD_LAT_RST = 10,
    parameter int          WR_LAT_RST = 10,
    parameter int          PF_EN_RST  = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    state_t state_q, state_d;
    logic [7:0] cnt_q;
    logic is_mem, is_we, is_hit;
    logic ack_q;
    logic [31:0] dat_q;

    logic [7:0] rd_lat, wr_lat;
    logic pf_en;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, pf_cnt;

    logic pf_pend, pf_valid;
    logic [MEM_AW-1:0] pf_addr, pf_next;
    logic [31:0] pf_data;

    logic [MEM_AW-1:0] bram_addr;
    logic [3:0] bram_we;
    logic [31:0] bram_rdata;
    logic [31:0] csr_rdata, rd_mux;

    logic [MEM_AW-1:0] word;
    logic [19:0] csr_off;
    logic mem_sel, csr_sel, req, req_ok, pf_hit;
    logic acking, csr_wr, ctrl_wr;
    logic [7:0] lat;
    logic unused_adr;

    assign word       = wbs_adr_i[MEM_AW+1:2];
    assign csr_off    = {wbs_adr_i[19:2], 2'b00};
    assign mem_sel    = wbs_adr_i[31:20] == MEM_BASE;
    assign csr_sel    = wbs_adr_i[31:20] == CSR_BASE;
    assign req        = wbs_cyc_i & wbs_stb_i & (mem_sel | csr_sel);
    // The cycle while ack is high is the bubble: stb may still be up.
    assign req_ok     = req & ~ack_q;
    assign pf_hit     = mem_sel & ~wbs_we_i & pf_valid & (pf_addr == word);
    assign lat        = wbs_we_i ? wr_lat
                      : ((rd_lat == 8'd0) ? 8'd1 : rd_lat);
    assign acking     = state_q == ST_ACK;
    assign csr_wr     = acking & ~is_mem & is_we;
    assign ctrl_wr    = csr_wr & (csr_off == CSR_CTRL);
    assign unused_adr = ^wbs_adr_i[1:0];

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;

    // Background prefetch steers the BRAM address while entering PF.
    assign bram_addr = (state_q == ST_IDLE && state_d == ST_PF)
                     ? pf_next : word;
    assign bram_we   = (acking & is_mem & is_we & ~wb_rst_i)
                     ? wbs_sel_i : 4'b0000;

    exmem_bram #(
        .AW (MEM_AW)
    ) u_bram (
        .clk   (wb_clk_i),
        .addr  (bram_addr),
        .we    (bram_we),
        .wdata (wbs_dat_i),
        .rdata (bram_rdata)
    );

    // Next-state decode of the access sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    if (!mem_sel || pf_hit || lat == 8'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (pf_pend) begin
                    state_d = ST_PF;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_PF:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, wait counter and request kind captured at E0.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            is_mem  <= 1'b0;
            is_we   <= 1'b0;
            is_hit  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_ok) begin
                cnt_q  <= lat - 8'd1;
                is_mem <= mem_sel;
                is_we  <= wbs_we_i;
                is_hit <= pf_hit;
            end else if (state_q == ST_WAIT && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    // CSR read multiplexer.
    always_comb begin
        csr_rdata = 32'd0;
        case (csr_off)
            CSR_CTRL:   csr_rdata = {15'd0, pf_en, wr_lat, rd_lat};
            CSR_RD_CNT: csr_rdata = rd_cnt;
            CSR_WR_CNT: csr_rdata = wr_cnt;
            CSR_PF_HIT: csr_rdata = pf_cnt;
            default:    csr_rdata = 32'd0;
        endcase
    end

    // Source of read data for the current ack.
    always_comb begin
        rd_mux = csr_rdata;
        if (is_mem) begin
            rd_mux = is_hit ? pf_data : bram_rdata;
        end
    end

    // Single-cycle ack; read data is zero outside the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= acking;
            dat_q <= (acking && !is_we) ? rd_mux : 32'd0;
        end
    end

    // CTRL register and saturating access counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_lat <= 8'(RD_LAT_RST);
            wr_lat <= 8'(WR_LAT_RST);
            pf_en  <= 1'(PF_EN_RST);
            rd_cnt <= '0;
            wr_cnt <= '0;
            pf_cnt <= '0;
        end else begin
            if (acking && is_mem) begin
                if (is_we) begin
                    wr_cnt <= sat_inc(wr_cnt);
                end else begin
                    rd_cnt <= sat_inc(rd_cnt);
                    if (is_hit) begin
                        pf_cnt <= sat_inc(pf_cnt);
                    end
                end
            end
            if (csr_wr) begin
                case (csr_off)
                    CSR_CTRL: begin
                        if (wbs_sel_i[0]) rd_lat <= wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) wr_lat <= wbs_dat_i[15:8];
                        if (wbs_sel_i[2]) pf_en  <= wbs_dat_i[16];
                    end
                    CSR_RD_CNT: rd_cnt <= '0;
                    CSR_WR_CNT: wr_cnt <= '0;
                    CSR_PF_HIT: pf_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

    // One-entry sequential prefetch buffer.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pf_pend  <= 1'b0;
            pf_valid <= 1'b0;
            pf_addr  <= '0;
            pf_next  <= '0;
            pf_data  <= 32'd0;
        end else begin
            if (state_q == ST_IDLE && req_ok) begin
                pf_pend <= 1'b0;
            end
            if (state_q == ST_PF) begin
                pf_valid <= 1'b1;
                pf_addr  <= pf_next;
                pf_data  <= bram_rdata;
                pf_pend  <= 1'b0;
            end
            if (acking && is_mem && !is_we && pf_en) begin
                pf_pend  <= 1'b1;
                pf_valid <= 1'b0;
                pf_next  <= word + MEM_AW'(1);
            end
            if ((acking && is_mem && is_we) || ctrl_wr || !pf_en) begin
                pf_pend  <= 1'b0;
                pf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_exmem_ctrl.sv
// Bench for wb_exmem_ctrl: directed plan steps plus random traffic
// checked against a transaction-level model of memory, CSRs and prefetch.
module tb_wb_exmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat;

    int errors = 0;
    int checks = 0;

    bit [31:0] m_mem [4096];
    bit [7:0]  m_rdlat, m_wrlat;
    bit        m_pfen, m_pfv;
    int        m_pfa;
    bit [31:0] m_rd, m_wr, m_pf;

    bit [11:0] offs [5] = '{12'h0, 12'h4, 12'h8, 12'hC, 12'h10};

    always #5 clk = ~clk;

    wb_exmem_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic bit [31:0] sat(input bit [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic bit [31:0] madr(input int w);
        return {12'h380, 6'd0, w[11:0], 2'b00};
    endfunction

    function automatic bit [31:0] cadr(input bit [11:0] off);
        return {12'h381, 8'd0, off};
    endfunction

    function automatic void model_reset();
        m_rdlat = 8'd10;
        m_wrlat = 8'd10;
        m_pfen  = 1'b0;
        m_pfv   = 1'b0;
        m_pfa   = 0;
        m_rd    = 32'd0;
        m_wr    = 32'd0;
        m_pf    = 32'd0;
    endfunction

    // One classic cycle; edges counts posedges from E0 (=1) to ack.
    task automatic bus(input bit w_en, input bit [31:0] a,
                       input bit [31:0] d, input bit [3:0] s,
                       input int budget, output bit acked,
                       output int edges, output bit [31:0] rd,
                       output bit dirty);
        acked = 1'b0;
        edges = 0;
        rd    = 32'd0;
        dirty = 1'b0;
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w_en;
        adr  = a;
        wdat = d;
        sel  = s;
        while (!acked && edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack) begin
                acked = 1'b1;
                rd    = rdat;
            end else if (rdat != 32'd0) begin
                dirty = 1'b1;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_mem(input bit w_en, input int w,
                          input bit [31:0] d, input bit [3:0] s,
                          input string tag);
        bit hit, acked, dirty;
        int lat, edges;
        bit [31:0] rd;
        hit = !w_en && m_pfen && m_pfv && (m_pfa == w);
        if (w_en) lat = m_wrlat;
        else if (hit) lat = 0;
        else lat = (m_rdlat == 8'd0) ? 1 : int'(m_rdlat);
        bus(w_en, madr(w), d, s, lat + 20, acked, edges, rd, dirty);
        chk({tag, "_ack"}, 32'(acked), 32'd1);
        chk({tag, "_lat"}, 32'(edges - 1), 32'(lat + 1));
        chk({tag, "_dat0"}, 32'(dirty), 32'd0);
        if (!w_en) begin
            chk({tag, "_data"}, rd, m_mem[w]);
            m_rd = sat(m_rd);
            if (hit) m_pf = sat(m_pf);
            if (m_pfen) begin
                m_pfv = 1'b1;
                m_pfa = (w + 1) % 4096;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
            end
            m_wr  = sat(m_wr);
            m_pfv = 1'b0;
        end
    endtask

    task automatic do_csr(input bit w_en, input bit [11:0] off,
                          input bit [31:0] d, input bit [3:0] s,
                          input string tag);
        bit acked, dirty;
        int edges;
        bit [31:0] rd, want;
        case (off)
            12'h0:   want = {15'd0, m_pfen, m_wrlat, m_rdlat};
            12'h4:   want = m_rd;
            12'h8:   want = m_wr;
            12'hC:   want = m_pf;
            default: want = 32'd0;
        endcase
        bus(w_en, cadr(off), d, s, 20, acked, edges, rd, dirty);
        chk({tag, "_ack"}, 32'(acked), 32'd1);
        chk({tag, "_lat"}, 32'(edges - 1), 32'd1);
        if (!w_en) begin
            chk({tag, "_data"}, rd, want);
        end else begin
            case (off)
                12'h0: begin
                    if (s[0]) m_rdlat = d[7:0];
                    if (s[1]) m_wrlat = d[15:8];
                    if (s[2]) m_pfen  = d[16];
                    m_pfv = 1'b0;
                end
                12'h4:   m_rd = 32'd0;
                12'h8:   m_wr = 32'd0;
                12'hC:   m_pf = 32'd0;
                default: ;
            endcase
        end
    endtask

    task automatic set_ctrl(input bit [7:0] rl, input bit [7:0] wl,
                            input bit pf);
        do_csr(1'b1, 12'h0, {15'd0, pf, wl, rl}, 4'b0111, "ctrl_wr");
    endtask

    function automatic int pick();
        int r;
        r = int'($urandom_range(0, 16));
        return (r == 16) ? 4095 : r;
    endfunction

    initial begin
        bit acked, dirty;
        int edges, last, acks;
        bit [31:0] rd;
        bit [7:0] sweep_rd [4];
        bit [7:0] sweep_wr [2];
        sweep_rd = '{8'd0, 8'd1, 8'd5, 8'd255};
        sweep_wr = '{8'd0, 8'd3};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_csr(1'b0, 12'h0, 32'd0, 4'hF, "rst_ctrl");
        chk("rst_ctrl_model", {15'd0, m_pfen, m_wrlat, m_rdlat},
            32'h0000_0A0A);
        do_csr(1'b0, 12'h4, 32'd0, 4'hF, "rst_rdcnt");
        do_csr(1'b0, 12'h8, 32'd0, 4'hF, "rst_wrcnt");
        do_csr(1'b0, 12'hC, 32'd0, 4'hF, "rst_pfhit");

        do_mem(1'b1, 3, 32'h1234_5678, 4'hF, "dflt_wr");
        do_mem(1'b0, 3, 32'd0, 4'hF, "dflt_rd");

        for (int i = 0; i < 17; i++) begin
            do_mem(1'b1, (i == 16) ? 4095 : i, $urandom, 4'hF, "fill");
        end

        foreach (sweep_rd[i]) begin
            set_ctrl(sweep_rd[i], 8'd2, 1'b0);
            do_mem(1'b0, 3, 32'd0, 4'hF, "rdlat");
        end
        foreach (sweep_wr[i]) begin
            set_ctrl(8'd1, sweep_wr[i], 1'b0);
            do_mem(1'b1, 4, $urandom, 4'hF, "wrlat");
        end

        do_mem(1'b1, 5, 32'hFFFF_FFFF, 4'hF, "byte_ff");
        do_mem(1'b1, 5, 32'h0000_0000, 4'b0101, "byte_sel");
        do_mem(1'b0, 5, 32'd0, 4'hF, "byte_rd");
        chk("byte_model", m_mem[5], 32'hFF00_FF00);

        set_ctrl(8'd4, 8'd2, 1'b1);
        do_csr(1'b1, 12'hC, 32'd0, 4'hF, "pf_clr");
        do_mem(1'b0, 7, 32'd0, 4'hF, "pf_rd7");
        do_mem(1'b0, 8, 32'd0, 4'hF, "pf_hit8");
        do_csr(1'b0, 12'hC, 32'd0, 4'hF, "pf_cnt1");
        do_mem(1'b0, 4095, 32'd0, 4'hF, "pf_last");
        do_mem(1'b0, 0, 32'd0, 4'hF, "pf_wrap");
        do_mem(1'b0, 7, 32'd0, 4'hF, "pf_rd7b");
        do_mem(1'b1, 8, $urandom, 4'hF, "pf_wr8");
        do_mem(1'b0, 8, 32'd0, 4'hF, "pf_miss8");

        last = -1;
        for (int i = 0; i < 80; i++) begin
            int k, w;
            k = int'($urandom_range(0, 9));
            w = pick();
            if (k <= 4) begin
                if (k <= 2 && last >= 0 && (last < 15 || last == 4095)) begin
                    w = (last + 1) % 4096;
                end
                do_mem(1'b0, w, 32'd0, 4'hF, "rnd_rd");
                last = w;
            end else if (k <= 6) begin
                do_mem(1'b1, w, $urandom, 4'($urandom), "rnd_wr");
            end else if (k == 7) begin
                set_ctrl(8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                         1'($urandom));
            end else if (k == 8) begin
                do_csr(1'b0, offs[$urandom_range(0, 4)], 32'd0, 4'hF,
                       "rnd_csr");
            end else begin
                do_csr(1'b1, offs[$urandom_range(1, 4)], $urandom, 4'hF,
                       "rnd_clr");
            end
        end

        do_csr(1'b1, 12'h4, 32'hDEAD_BEEF, 4'hF, "cnt_clr");
        do_csr(1'b0, 12'h4, 32'd0, 4'hF, "cnt_clr_rd");

        set_ctrl(8'd2, 8'd2, 1'b0);
        @(negedge clk);
        force dut.rd_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt;
        m_rd = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            do_mem(1'b0, i, 32'd0, 4'hF, "sat_rd");
        end
        do_csr(1'b0, 12'h4, 32'd0, 4'hF, "sat_cnt");
        chk("sat_model", m_rd, 32'hFFFF_FFFF);

        bus(1'b0, 32'h3820_0000, 32'd0, 4'hF, 300, acked, edges, rd, dirty);
        chk("unmapped_noack", 32'(acked), 32'd0);

        set_ctrl(8'd2, 8'd10, 1'b0);
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = madr(9);
        wdat = ~m_mem[9];
        sel  = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        acks = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        chk("midrst_noack", 32'(acks), 32'd0);
        model_reset();
        do_csr(1'b0, 12'h0, 32'd0, 4'hF, "midrst_ctrl");
        do_mem(1'b0, 9, 32'd0, 4'hF, "midrst_keep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
